// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: shared types for the iterative multiply/divide slice.
// Carries the op_x encodings used by decode and EXE, the sequencer state
// type and the double-width accumulator type.
package muldiv_sequencer_pkg;

  // op_x subfield of the decoded EXE packet.
  typedef logic [2:0] lc3b_op_x;

  localparam lc3b_op_x op_add    = 3'd0;
  localparam lc3b_op_x op_and    = 3'd1;
  localparam lc3b_op_x op_not    = 3'd2;
  localparam lc3b_op_x op_sub    = 3'd3;
  localparam lc3b_op_x op_mul    = 3'd4;
  localparam lc3b_op_x op_div    = 3'd5;
  localparam lc3b_op_x op_hi_mul = 3'd6;
  localparam lc3b_op_x op_rem    = 3'd7;

  // Double-width word: the full product of two 16-bit operands.
  typedef logic [31:0] lc3b_dword;

  // Multiply/divide sequencer states. md_fixup is only entered when the
  // signed-operand build is selected.
  typedef enum logic [1:0] {
    md_idle,
    md_calc,
    md_fixup,
    md_done
  } lc3b_muldiv_state;

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath: operand registers, shift-add product accumulator and
// restoring-division remainder/quotient registers. The sequencer drives it
// with load (capture operands, clear state), step (one bit per cycle) and,
// when MULDIV_SIGNED_EN is defined, fixup (sign correction of the result).
// res_lo/res_hi show the value the result registers would take this cycle:
// the post-step value during step, the sign-corrected value during fixup.
module muldiv_datapath
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
`ifdef MULDIV_SIGNED_EN
  input  logic             fixup,
`endif
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  logic [WIDTH-1:0]   a_q;        // multiplicand / dividend
  logic [WIDTH-1:0]   b_q;        // multiplier / divisor
  logic [2*WIDTH-1:0] acc_q;      // product accumulator
  logic [WIDTH-1:0]   rem_q;      // partial remainder
  logic [WIDTH-1:0]   quot_q;     // quotient under construction
  logic               div_q;      // latched operation: 1 = divide

  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [CNT_W-1:0]   rev_idx;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   rem_shift;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quot_step;

`ifdef MULDIV_SIGNED_EN
  logic neg_lo_q, neg_hi_q;       // result halves needing negation
  logic neg_lo_d, neg_hi_d;
`endif

  // Operand conditioning: magnitudes and result signs in the signed build.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the if/case can leave it unassigned and infer a latch.
    a_mag = op_a;
    b_mag = op_b;
`ifdef MULDIV_SIGNED_EN
    // Product sign covers both halves; remainder takes the dividend's sign.
    neg_lo_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
    neg_hi_d = is_div ? op_a[WIDTH-1] : neg_lo_d;
    if (op_a[WIDTH-1]) a_mag = -op_a;
    if (op_b[WIDTH-1]) b_mag = -op_b;
`endif
  end

  // One iteration: shift-add for multiply, restoring step for divide.
  always_comb begin
    // Divide consumes dividend bits MSB first, so it walks the counter backwards.
    rev_idx   = CNT_W'(WIDTH - 1) - count;
    acc_step  = acc_q;
    if (b_q[count]) acc_step = acc_q + ({{WIDTH{1'b0}}, a_q} << count);
    // The partial remainder stays below the dividend prefix, which is under
    // 2**(WIDTH-1) until the final step, so dropping rem_q's MSB loses nothing.
    rem_shift = {rem_q[WIDTH-2:0], a_q[rev_idx]};
    rem_step  = rem_shift;
    quot_step = quot_q;
    if (rem_shift >= b_q) begin
      rem_step           = rem_shift - b_q;
      quot_step[rev_idx] = 1'b1;
    end
  end

  // Operand and iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the evaluation order of blocks is irrelevant.
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      div_q  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else if (load) begin
      a_q    <= a_mag;
      b_q    <= b_mag;
      acc_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
      div_q  <= is_div;
`ifdef MULDIV_SIGNED_EN
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
`endif
    end else if (step) begin
      if (div_q) begin
        rem_q  <= rem_step;
        quot_q <= quot_step;
      end else begin
        acc_q  <= acc_step;
      end
    end
  end

  // Result view presented to the sequencer's lo/hi registers.
  always_comb begin
    if (div_q) {res_hi, res_lo} = {rem_step, quot_step};
    else       {res_hi, res_lo} = acc_step;
`ifdef MULDIV_SIGNED_EN
    if (fixup) begin
      if (div_q) begin
        res_lo = neg_lo_q ? -quot_q : quot_q;
        res_hi = neg_hi_q ? -rem_q  : rem_q;
      end else begin
        {res_hi, res_lo} = neg_lo_q ? -acc_q : acc_q;
      end
    end
`endif
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle controller for the op_x MUL/DIV unit.
// Accepts an operation from EXE, stalls the front of the pipeline for one
// iteration per operand bit, then pulses done with the result in lo/hi, which
// HI_MUL/REM and MUL/DIV writeback read later without stalling.
// Optional build macro MULDIV_SIGNED_EN: two's complement operands, with an
// extra FIXUP cycle that applies the result signs.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4      // 2**CNT_W must equal WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op_x_bits,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_by_zero
);

  lc3b_muldiv_state state_q, state_d;
  logic [CNT_W-1:0] count_q;

  logic             op_ok;
  logic             accept;
  logic             div_zero;
  logic             last_step;
  logic             dp_load;
  logic             dp_step;
  logic             capture;
  logic [WIDTH-1:0] dp_lo;
  logic [WIDTH-1:0] dp_hi;
`ifdef MULDIV_SIGNED_EN
  logic             dp_fixup;
`endif

  // Only MUL and DIV are taken; flush wins over a simultaneous start.
  assign op_ok     = (op_x_bits == op_mul) || (op_x_bits == op_div);
  assign accept    = (state_q == md_idle) && start && !flush && op_ok;
  assign div_zero  = (op_x_bits == op_div) && (opB == '0);
  assign last_step = (count_q == CNT_W'(WIDTH - 1));

  // The accept term is combinational so the packet stays in EXE on the
  // acceptance cycle; an ignored op_x value never stalls.
  assign stall = (state_q == md_calc) || (state_q == md_fixup) || accept;
  assign done  = (state_q == md_done);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= md_idle;
    else        state_q <= state_d;
  end

  // Next state and datapath strobes.
  always_comb begin
    state_d = state_q;
    dp_load = 1'b0;
    dp_step = 1'b0;
    capture = 1'b0;
`ifdef MULDIV_SIGNED_EN
    dp_fixup = 1'b0;
`endif
    case (state_q)
      md_idle: begin
        if (accept) begin
          dp_load = 1'b1;
          // Divide by zero needs no iterations: its result is loaded directly.
          state_d = div_zero ? md_done : md_calc;
        end
      end
      md_calc: begin
        if (flush) begin
          state_d = md_idle;
        end else begin
          dp_step = 1'b1;
          if (last_step) begin
`ifdef MULDIV_SIGNED_EN
            state_d = md_fixup;
`else
            capture = 1'b1;
            state_d = md_done;
`endif
          end
        end
      end
`ifdef MULDIV_SIGNED_EN
      md_fixup: begin
        // Still part of the stalled operation, so a flush aborts it here too.
        if (flush) begin
          state_d = md_idle;
        end else begin
          dp_fixup = 1'b1;
          capture  = 1'b1;
          state_d  = md_done;
        end
      end
`endif
      md_done: state_d = md_idle;   // done pulses even if flush is asserted
      default: state_d = md_idle;
    endcase
  end

  // Iteration counter: one bit of the operation per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       count_q <= '0;
    else if (dp_load) count_q <= '0;
    else if (dp_step) count_q <= count_q + CNT_W'(1);
  end

  // Result registers: hold until the next accepted operation completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo <= '0;
      hi <= '0;
    end else if (accept && div_zero) begin
      lo <= '1;
      hi <= opA;
    end else if (capture) begin
      lo <= dp_lo;
      hi <= dp_hi;
    end
  end

  // Sticky divide-by-zero flag, re-evaluated on every accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      div_by_zero <= 1'b0;
    else if (accept) div_by_zero <= div_zero;
  end

  muldiv_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (dp_load),
    .step   (dp_step),
`ifdef MULDIV_SIGNED_EN
    .fixup  (dp_fixup),
`endif
    .is_div (op_x_bits == op_div),
    .op_a   (opA),
    .op_b   (opB),
    .count  (count_q),
    .res_lo (dp_lo),
    .res_hi (dp_hi)
  );

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller for the iterative multiply/divide unit behind the op_x MUL/DIV instructions.
- Accepts an operation from the EXE stage when the decoded packet asserts load_alg_reg.
- Holds the pipeline with a stall while it iterates, then exposes lo and hi result registers.
- Later op_x HI_MUL/REM and normal MUL/DIV writeback select those registers through alu_res_sel.

Parameters:
WIDTH, 16, operand and result width in bits
CNT_W, 4, iteration counter width; must satisfy 2**CNT_W == WIDTH

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  EXE-stage packet load_alg_reg, qualified by the stage's valid bit
op_x_bits  input  3  op_x subfield; op_mul or op_div from lc3b_types
opA  input  WIDTH  multiplicand / dividend (forwarded SR1 value)
opB  input  WIDTH  multiplier / divisor (forwarded SR2 value)
flush  input  1  pipeline flush; aborts the operation in flight
stall  output  1  hold IF/ID/EXE pipeline registers
done  output  1  one-cycle pulse; lo/hi valid
lo  output  WIDTH  product[WIDTH-1:0] or quotient
hi  output  WIDTH  product[2*WIDTH-1:WIDTH] or remainder
div_by_zero  output  1  sticky flag for last DIV with opB==0; cleared by next accepted start

Behaviour:
- Clock and reset: single clock, clk. Reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE; count=0.
  - lo, hi, stall, done and div_by_zero all 0.
- States: IDLE, CALC, DONE (plus FIXUP when the optional feature is enabled).
- Stall output: stall = (state==CALC) | (state==IDLE & start & ~flush). Purely combinational, so the packet stays in EXE during the accept cycle.
- IDLE:
  - Acceptance requires start & ~flush & op_x_bits in {op_mul, op_div}. Any other op_x_bits value is ignored.
  - On acceptance: latch opA, opB and the op; clear the accumulator and div_by_zero; set count=0.
  - Next state is CALC, except DIV with opB==0 goes straight to DONE with lo=16'hFFFF, hi=opA, div_by_zero=1.
- CALC, one bit per cycle:
  - MUL: shift-add. If multiplier bit[count] is set, add multiplicand<<count into the 2*WIDTH-bit accumulator. Unsigned; the carry out of the top is discarded.
  - DIV: restoring division. rem = {rem[WIDTH-2:0], dividend[WIDTH-1-count]}. If rem >= divisor, subtract and set quotient bit WIDTH-1-count.
  - count increments every cycle. When count==WIDTH-1, load lo/hi and go to DONE.
- DONE: done=1 and stall=0 for exactly one cycle, then return to IDLE.
- Latency:
  - start accepted in cycle 0; CALC occupies cycles 1..16; done in cycle 17.
  - stall is high in cycles 0..16.
  - Divide-by-zero: done in cycle 1, stall only in cycle 0.
- Result holding: lo/hi hold their values until the next accepted start completes. A later HI_MUL/REM reads them with no stall.
- Busy behaviour: start while not in IDLE is ignored. The EXE packet is frozen, so no second request can arrive.
- Flush:
  - In CALC: return to IDLE next cycle; lo/hi unchanged; no done.
  - In DONE: done still pulses.
  - In IDLE: flush overrides start.
- Reset mid-operation: immediate return to IDLE with all outputs 0.

Optional Feature:
MULDIV_SIGNED_EN
- Defined: operands are treated as two's complement.
  - In IDLE, latch magnitudes and record the result signs. MUL sign = signA^signB. For DIV, quotient sign = signA^signB and remainder sign = signA.
  - After CALC, a FIXUP state negates results as required. FIXUP then goes to DONE, adding one cycle: done in cycle 18, stall high in cycles 0..17.
  - 0x8000 / 0xFFFF gives lo=0x8000, hi=0 (wraps).
- Undefined: unsigned only; FIXUP does not exist.

Decomposition:
- lc3b_types additions:
  - lc3b_muldiv_state enum {md_idle, md_calc, md_fixup, md_done}.
  - lc3b_dword typedef (32-bit) for the accumulator.
  - Reuses the existing op_mul/op_div constants; they are not redefined.
- Sub-module muldiv_datapath: holds the accumulator/remainder/quotient shift registers and the adder/subtractor, driven by per-cycle step/load/fixup strobes.
- muldiv_sequencer keeps the FSM, the counter, stall/done generation and the lo/hi registers.

Test Plan:
- MUL opA=3, opB=5 -> stall cycles 0..16; done in cycle 17; lo=0x000F, hi=0x0000.
- MUL 0xFFFF*0xFFFF -> lo=0x0001, hi=0xFFFE; lo/hi still hold 3 cycles later with start=0.
- DIV 100/7 -> lo=0x000E, hi=0x0002, div_by_zero=0; a following DIV 0x1234/0 -> done in cycle 1, lo=0xFFFF, hi=0x1234, div_by_zero=1.
- Flush:
  - MUL 3*5 completes: lo=0x000F.
  - Then MUL 9*9; assert flush in cycle 8 -> IDLE at cycle 9; stall low; no done; lo still 0x000F.
  - Reset mid-CALC -> all outputs 0 immediately.
- start with op_x_bits=op_sub -> no stall, no state change; start held high during CALC -> exactly one done.
- With MULDIV_SIGNED_EN:
  - MUL 0xFFFA*7 -> lo=0xFFD6, hi=0xFFFF, done in cycle 18.
  - DIV 0xFFF9/2 -> lo=0xFFFD, hi=0xFFFF.
